// File: rtl/memory_unit.sv
// memory_unit: word/byte addressable memory behind a wait-state handshake.
// A request is latched in IDLE, held for WAIT_CYCLES in WAIT, and completed
// with a one-cycle MemRdy pulse in DONE.
// Optional feature macro: MEM_ALIGN_CHECK_EN -- flags word accesses whose
// address is not word aligned (MemErr with MemRdy, no write, zero read data).
module memory_unit #(
    parameter int DEPTH_WORDS = 1024,
    parameter int WAIT_CYCLES = 2
) (
    input  logic        Clk,
    input  logic        Reset,
    input  logic [23:0] MemAddr,
    input  logic [31:0] toMemData,
    input  logic        MemLength,
    input  logic        MemRd,
    input  logic        MemWr,
    input  logic        MemEnable,
    output logic [31:0] fromMemData,
    output logic        MemRdy,
    output logic        Busy,
    output logic        MemErr
);
    localparam int AW = $clog2(DEPTH_WORDS);
    // Only the byte-address bits that select a word and a lane are kept;
    // higher address bits alias onto the same words.
    localparam int LW = AW + 2;
    localparam logic [3:0] WAIT_INIT = 4'(WAIT_CYCLES);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_WAIT = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    typedef struct packed {
        logic [LW-1:0] addr;
        logic [31:0]   data;
        logic          len;   // 1 = word, 0 = byte
        logic          rd;    // 1 = read, 0 = write
        logic          err;   // misaligned word access
    } req_t;

    state_t      state, state_nxt;
    logic [3:0]  cnt;
    req_t        cur, lat, eff;
    logic [31:0] mem [DEPTH_WORDS];
    logic        req_ok, accept, enter_done;
    logic [31:0] rd_word, rd_val;
    logic        unused_addr;

    assign unused_addr = ^MemAddr[23:LW];
    assign req_ok      = MemEnable & (MemRd | MemWr);
    assign accept      = (state == ST_IDLE) & req_ok;

    // Decode the live request; a read wins when both qualifiers are set.
    always_comb begin
        cur.addr = MemAddr[LW-1:0];
        cur.data = toMemData;
        cur.len  = MemLength;
        cur.rd   = MemRd;
`ifdef MEM_ALIGN_CHECK_EN
        cur.err  = MemLength & (MemAddr[1:0] != 2'b00);
`else
        cur.err  = 1'b0;
`endif
    end

    // With zero wait states DONE is entered on the accepting edge itself,
    // before the latch holds the request, so the live request is used then.
    assign eff = (state == ST_IDLE) ? cur : lat;

    // State register.
    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) state <= ST_IDLE;
        else       state <= state_nxt;
    end

    // Next-state logic.
    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE: if (req_ok) state_nxt = (WAIT_CYCLES == 0) ? ST_DONE : ST_WAIT;
            ST_WAIT: if (cnt <= 4'd1) state_nxt = ST_DONE;
            ST_DONE: state_nxt = ST_IDLE;
            default: state_nxt = ST_IDLE;
        endcase
    end

    // Handshake outputs decoded from the current state.
    always_comb begin
        MemRdy = (state == ST_DONE);
        Busy   = (state != ST_IDLE);
`ifdef MEM_ALIGN_CHECK_EN
        MemErr = (state == ST_DONE) & lat.err;
`else
        MemErr = 1'b0;
`endif
    end

    // Capture the request on accept and count down the wait states.
    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            cnt <= '0;
            lat <= '0;
        end else if (accept) begin
            cnt <= WAIT_INIT;
            lat <= cur;
        end else if (state == ST_WAIT) begin
            cnt <= cnt - 4'd1;
        end
    end

    // Read path: select the whole word or one zero-extended byte lane.
    assign rd_word = mem[eff.addr[LW-1:2]];

    // Erroring accesses return zero instead of array data.
    always_comb begin
        rd_val = '0;
        if (!eff.err) begin
            if (eff.len) rd_val = rd_word;
            else         rd_val = {24'h0, rd_word[{eff.addr[1:0], 3'b000} +: 8]};
        end
    end

    assign enter_done = (state_nxt == ST_DONE) & (state != ST_DONE);

    // Read data is loaded as DONE is entered and held until the next read;
    // plain writes leave it untouched.
    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset)                             fromMemData <= '0;
        else if (enter_done && (eff.rd || eff.err)) fromMemData <= rd_val;
    end

    // Writes commit on the DONE->IDLE edge; the array itself is never reset.
    always_ff @(posedge Clk) begin
        if (state == ST_DONE && !lat.rd && !lat.err) begin
            if (lat.len) mem[lat.addr[LW-1:2]] <= lat.data;
            else         mem[lat.addr[LW-1:2]][{lat.addr[1:0], 3'b000} +: 8] <= lat.data[7:0];
        end
    end

endmodule

// File: tb/tb_memory_unit.sv
// tb_memory_unit: scoreboard bench for memory_unit. Instance 0 uses two wait
// states, instance 1 uses none; both share the request buses but have
// separate enables. Expected results are pushed when a request is driven
// and popped when MemRdy is seen.
module tb_memory_unit;
    typedef struct {
        logic [31:0] data;
        logic        err;
    } exp_t;

    typedef struct packed {
        logic        rd;
        logic        wr;
        logic        len;
        logic [23:0] addr;
        logic [31:0] data;
    } op_t;

    localparam int LAT0 = 3;   // WAIT_CYCLES=2 instance
    localparam int LAT1 = 1;   // WAIT_CYCLES=0 instance

    logic        Clk = 1'b0;
    logic        Reset = 1'b1;
    logic [23:0] MemAddr = '0;
    logic [31:0] toMemData = '0;
    logic        MemLength = 1'b0;
    logic        MemRd = 1'b0;
    logic        MemWr = 1'b0;
    logic [1:0]  en = '0;
    logic [1:0][31:0] rdata;
    logic [1:0]  rdy, busy, err;

    int n_cmp = 0;
    int n_fail = 0;
    exp_t sbq [$];
    logic [31:0] model [2][1024];
    logic [31:0] last_rd [2];

    always #5 Clk = ~Clk;

    memory_unit #(.DEPTH_WORDS(1024), .WAIT_CYCLES(2)) u_dut (
        .Clk(Clk), .Reset(Reset), .MemAddr(MemAddr), .toMemData(toMemData),
        .MemLength(MemLength), .MemRd(MemRd), .MemWr(MemWr), .MemEnable(en[0]),
        .fromMemData(rdata[0]), .MemRdy(rdy[0]), .Busy(busy[0]), .MemErr(err[0])
    );

    memory_unit #(.DEPTH_WORDS(1024), .WAIT_CYCLES(0)) u_dut0 (
        .Clk(Clk), .Reset(Reset), .MemAddr(MemAddr), .toMemData(toMemData),
        .MemLength(MemLength), .MemRd(MemRd), .MemWr(MemWr), .MemEnable(en[1]),
        .fromMemData(rdata[1]), .MemRdy(rdy[1]), .Busy(busy[1]), .MemErr(err[1])
    );

    // Reference model: compute the expected completion and update the model array.
    function automatic void expect_push(input int d, input logic rd, input logic len,
                                        input logic [23:0] addr, input logic [31:0] data);
        exp_t        e;
        logic [9:0]  idx;
        logic [1:0]  lane;
        logic [31:0] w;
        idx   = addr[11:2];
        lane  = addr[1:0];
        e.err = 1'b0;
`ifdef MEM_ALIGN_CHECK_EN
        e.err = len && (lane != 2'b00);
`endif
        w = model[d][idx];
        if (e.err) e.data = '0;
        else if (rd) e.data = len ? w : {24'h0, w[{lane, 3'b000} +: 8]};
        else begin
            if (len) w = data;
            else     w[{lane, 3'b000} +: 8] = data[7:0];
            model[d][idx] = w;
            e.data = last_rd[d];
        end
        if (rd || e.err) last_rd[d] = e.data;
        sbq.push_back(e);
    endfunction

    task automatic drive(input int d, input logic rd, input logic wr, input logic len,
                         input logic [23:0] addr, input logic [31:0] data);
        MemAddr = addr; toMemData = data; MemLength = len;
        MemRd = rd; MemWr = wr; en[d] = 1'b1;
    endtask

    task automatic issue(input int d, input op_t op);
        @(negedge Clk);
        drive(d, op.rd, op.wr, op.len, op.addr, op.data);
        expect_push(d, op.rd, op.len, op.addr, op.data);
    endtask

    // Count edges from the accepting edge (edge 1) until MemRdy; -1 on timeout.
    task automatic wait_rdy(input int d, output int lat, output exp_t obs);
        lat = -1; obs.data = '0; obs.err = 1'b0;
        for (int k = 1; k <= 20; k++) begin
            @(posedge Clk);
            @(negedge Clk);
            if (k == 1) begin en = '0; MemRd = 1'b0; MemWr = 1'b0; end
            if (rdy[d]) begin
                lat = k; obs.data = rdata[d]; obs.err = err[d];
                break;
            end
        end
    endtask

    task automatic test_reset();
        @(negedge Clk);
        n_cmp++; if (rdy[0] !== 1'b0) begin n_fail++; $display("FAIL reset_rdy: got %b want 0", rdy[0]); end
        n_cmp++; if (busy[0] !== 1'b0) begin n_fail++; $display("FAIL reset_busy: got %b want 0", busy[0]); end
        n_cmp++; if (err[0] !== 1'b0) begin n_fail++; $display("FAIL reset_err: got %b want 0", err[0]); end
        n_cmp++; if (rdata[0] !== 32'h0) begin n_fail++; $display("FAIL reset_data: got %h want 0", rdata[0]); end
        Reset = 1'b0;
    endtask

    task automatic test_word_rw();
        op_t ops [2] = '{'{1'b0, 1'b1, 1'b1, 24'h000010, 32'hDEADBEEF},
                         '{1'b1, 1'b0, 1'b1, 24'h000010, 32'h0}};
        int lat; exp_t obs, e;
        for (int i = 0; i < 2; i++) begin
            issue(0, ops[i]);
            wait_rdy(0, lat, obs);
            e = sbq.pop_front();
            n_cmp++; if (lat != LAT0) begin n_fail++; $display("FAIL word_rw[%0d] latency: got %0d want %0d", i, lat, LAT0); end
            n_cmp++; if (obs.data !== e.data) begin n_fail++; $display("FAIL word_rw[%0d] data: got %h want %h", i, obs.data, e.data); end
            @(negedge Clk);
            n_cmp++; if (rdy[0] !== 1'b0 || busy[0] !== 1'b0) begin n_fail++; $display("FAIL word_rw[%0d] pulse: rdy=%b busy=%b want 0 0", i, rdy[0], busy[0]); end
        end
    endtask

    task automatic test_byte_lanes();
        op_t ops [8] = '{'{1'b0, 1'b1, 1'b1, 24'h000010, 32'h11223344},
                         '{1'b0, 1'b1, 1'b0, 24'h000013, 32'hFFFFFFA5},
                         '{1'b1, 1'b0, 1'b1, 24'h000010, 32'h0},
                         '{1'b1, 1'b0, 1'b0, 24'h000012, 32'h0},
                         '{1'b1, 1'b0, 1'b0, 24'h000013, 32'h0},
                         '{1'b1, 1'b0, 1'b0, 24'h000010, 32'h0},
                         '{1'b0, 1'b1, 1'b0, 24'h000011, 32'h00000077},
                         '{1'b1, 1'b0, 1'b1, 24'h000010, 32'h0}};
        int lat; exp_t obs, e;
        for (int i = 0; i < 8; i++) begin
            issue(0, ops[i]);
            wait_rdy(0, lat, obs);
            e = sbq.pop_front();
            n_cmp++; if (lat != LAT0) begin n_fail++; $display("FAIL byte[%0d] latency: got %0d want %0d", i, lat, LAT0); end
            n_cmp++; if (obs.data !== e.data) begin n_fail++; $display("FAIL byte[%0d] data: got %h want %h", i, obs.data, e.data); end
        end
    endtask

    task automatic test_wrap();
        op_t ops [3] = '{'{1'b0, 1'b1, 1'b1, 24'h001004, 32'h12345678},
                         '{1'b1, 1'b0, 1'b1, 24'h000004, 32'h0},
                         '{1'b1, 1'b0, 1'b1, 24'hFF2004, 32'h0}};
        int lat; exp_t obs, e;
        for (int i = 0; i < 3; i++) begin
            issue(0, ops[i]);
            wait_rdy(0, lat, obs);
            e = sbq.pop_front();
            n_cmp++; if (obs.data !== e.data || lat != LAT0) begin n_fail++; $display("FAIL wrap[%0d]: got %h lat %0d want %h lat %0d", i, obs.data, lat, e.data, LAT0); end
        end
    endtask

    task automatic test_reset_inflight();
        op_t pre = '{1'b0, 1'b1, 1'b1, 24'h000020, 32'hCAFEF00D};
        op_t rd  = '{1'b1, 1'b0, 1'b1, 24'h000020, 32'h0};
        int lat; exp_t obs, e;
        logic seen;
        issue(0, pre);
        wait_rdy(0, lat, obs);
        e = sbq.pop_front();
        // Aborted write: not modelled and never expected to complete.
        @(negedge Clk);
        drive(0, 1'b0, 1'b1, 1'b1, 24'h000020, 32'hFFFFFFFF);
        @(posedge Clk);
        @(negedge Clk);
        en = '0; MemWr = 1'b0;
        n_cmp++; if (busy[0] !== 1'b1) begin n_fail++; $display("FAIL abort_inwait: busy=%b want 1", busy[0]); end
        #2 Reset = 1'b1;
        #1;
        n_cmp++; if (busy[0] !== 1'b0 || rdy[0] !== 1'b0) begin n_fail++; $display("FAIL abort_reset: busy=%b rdy=%b want 0 0", busy[0], rdy[0]); end
        n_cmp++; if (rdata[0] !== 32'h0) begin n_fail++; $display("FAIL abort_data: got %h want 0", rdata[0]); end
        last_rd[0] = '0; last_rd[1] = '0;
        @(negedge Clk);
        Reset = 1'b0;
        seen = 1'b0;
        repeat (6) begin @(negedge Clk); seen |= rdy[0]; end
        n_cmp++; if (seen !== 1'b0) begin n_fail++; $display("FAIL abort_no_rdy: rdy seen=%b want 0", seen); end
        issue(0, rd);
        wait_rdy(0, lat, obs);
        e = sbq.pop_front();
        n_cmp++; if (obs.data !== e.data || lat != LAT0) begin n_fail++; $display("FAIL abort_readback: got %h lat %0d want %h lat %0d", obs.data, lat, e.data, LAT0); end
    endtask

    task automatic test_align();
        op_t ops [4] = '{'{1'b0, 1'b1, 1'b1, 24'h000022, 32'h5A5A5A5A},
                         '{1'b1, 1'b0, 1'b1, 24'h000020, 32'h0},
                         '{1'b0, 1'b1, 1'b0, 24'h000021, 32'h000000C3},
                         '{1'b1, 1'b0, 1'b1, 24'h000023, 32'h0}};
        int lat; exp_t obs, e;
        for (int i = 0; i < 4; i++) begin
            issue(0, ops[i]);
            wait_rdy(0, lat, obs);
            e = sbq.pop_front();
            n_cmp++; if (lat != LAT0) begin n_fail++; $display("FAIL align[%0d] latency: got %0d want %0d", i, lat, LAT0); end
            n_cmp++; if (obs.err !== e.err) begin n_fail++; $display("FAIL align[%0d] err: got %b want %b", i, obs.err, e.err); end
            n_cmp++; if (obs.data !== e.data) begin n_fail++; $display("FAIL align[%0d] data: got %h want %h", i, obs.data, e.data); end
        end
    endtask

    task automatic test_rdwr_noop();
        op_t ops [2] = '{'{1'b1, 1'b1, 1'b1, 24'h000010, 32'h0BAD0BAD},
                         '{1'b1, 1'b0, 1'b1, 24'h000010, 32'h0}};
        int lat; exp_t obs, e;
        @(negedge Clk);
        drive(0, 1'b0, 1'b0, 1'b1, 24'h000010, 32'h0);
        @(posedge Clk);
        @(negedge Clk);
        n_cmp++; if (busy[0] !== 1'b0) begin n_fail++; $display("FAIL noop_idle: busy=%b want 0", busy[0]); end
        en = '0;
        for (int i = 0; i < 2; i++) begin
            issue(0, ops[i]);
            wait_rdy(0, lat, obs);
            e = sbq.pop_front();
            n_cmp++; if (obs.data !== e.data || lat != LAT0) begin n_fail++; $display("FAIL rdwr[%0d]: got %h lat %0d want %h lat %0d", i, obs.data, lat, e.data, LAT0); end
        end
    endtask

    task automatic test_back_to_back();
        op_t ops [2] = '{'{1'b0, 1'b1, 1'b1, 24'h000040, 32'hAAAA0001},
                         '{1'b0, 1'b1, 1'b1, 24'h000044, 32'hBBBB0002}};
        int lat; exp_t obs, e;
        for (int i = 0; i < 2; i++) begin
            issue(1, ops[i]);
            wait_rdy(1, lat, obs);
            e = sbq.pop_front();
            n_cmp++; if (lat != LAT1) begin n_fail++; $display("FAIL b2b_wr[%0d] latency: got %0d want %0d", i, lat, LAT1); end
            @(negedge Clk);
        end
        @(negedge Clk);
        drive(1, 1'b1, 1'b0, 1'b1, 24'h000040, 32'h0);
        expect_push(1, 1'b1, 1'b1, 24'h000040, 32'h0);
        @(posedge Clk);
        @(negedge Clk);
        e = sbq.pop_front();
        n_cmp++; if (rdy[1] !== 1'b1 || rdata[1] !== e.data) begin n_fail++; $display("FAIL b2b_rd0: rdy=%b data=%h want 1 %h", rdy[1], rdata[1], e.data); end
        drive(1, 1'b1, 1'b0, 1'b1, 24'h000044, 32'h0);
        expect_push(1, 1'b1, 1'b1, 24'h000044, 32'h0);
        @(posedge Clk);
        @(negedge Clk);
        n_cmp++; if (rdy[1] !== 1'b0) begin n_fail++; $display("FAIL b2b_gap: rdy=%b want 0", rdy[1]); end
        @(posedge Clk);
        @(negedge Clk);
        e = sbq.pop_front();
        n_cmp++; if (rdy[1] !== 1'b1 || rdata[1] !== e.data) begin n_fail++; $display("FAIL b2b_rd1: rdy=%b data=%h want 1 %h", rdy[1], rdata[1], e.data); end
        en = '0; MemRd = 1'b0;
        @(posedge Clk);
        @(negedge Clk);
        n_cmp++; if (rdy[1] !== 1'b0 || busy[1] !== 1'b0) begin n_fail++; $display("FAIL b2b_end: rdy=%b busy=%b want 0 0", rdy[1], busy[1]); end
    endtask

    initial begin
        last_rd[0] = '0;
        last_rd[1] = '0;
        test_reset();
        test_word_rw();
        test_byte_lanes();
        test_wrap();
        test_reset_inflight();
        test_align();
        test_rdwr_noop();
        test_back_to_back();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish within the time limit");
        $fatal(1, "watchdog");
    end

endmodule
